// File: rtl/debounce_pkg.sv
// Shared types, helpers and parameter checks for the multi-channel debouncer.
// Imported by debounce_channel and debounce_multi.
`ifndef DEBOUNCE_PKG_SV
`define DEBOUNCE_PKG_SV

`define DB_RANGE_CHECK(lbl, v, lo, hi) \
  if (!debounce_pkg::in_range((v), (lo), (hi))) begin : lbl \
    $error("debounce: parameter out of range"); \
  end

package debounce_pkg;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
  } btn_evt_t;

  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  function automatic bit in_range(
    input longint v,
    input longint lo,
    input longint hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic longint max_of(input int w);
    return (longint'(1) << w) - 1;
  endfunction

endpackage

`endif

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, polarity fix, debounce and long-press
// counters, registered press/release/long pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEBOUNCE_COUNT = 20,
  parameter int SYNC_STAGES    = 2,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int LONG_W         = 16,
  parameter int LONG_COUNT     = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick,
  input  logic     btn_in,
  output btn_evt_t evt
);

  localparam logic IDLE = idle_level(ACTIVE_LOW);
  localparam bit   LONG_EN = (LONG_COUNT > 0);
  localparam logic [CNT_W-1:0] CNT_TOP =
    CNT_W'(DEBOUNCE_COUNT - 1);
  localparam logic [LONG_W-1:0] LONG_TOP =
    LONG_W'(LONG_EN ? LONG_COUNT - 1 : 0);
  localparam logic [LONG_W-1:0] LONG_SAT =
    LONG_W'(LONG_COUNT);

  `DB_RANGE_CHECK(g_chk_sync, SYNC_STAGES, 2, 4)
  `DB_RANGE_CHECK(g_chk_cnt, DEBOUNCE_COUNT, 1, max_of(CNT_W))
  `DB_RANGE_CHECK(g_chk_long, LONG_COUNT, 0, max_of(LONG_W))

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LONG_W-1:0]      lcnt_q, lcnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic rel_q, rel_d;
  logic long_q, long_d;
  logic s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
    s       = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_TOP) begin
        level_d = s;
        cnt_d   = '0;
        press_d = s;
        rel_d   = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // lcnt parks at LONG_COUNT so the pulse fires once per press
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (!LONG_EN || !level_q) begin
      lcnt_d = '0;
    end else if (tick) begin
      unique case (1'b1)
        (lcnt_q == LONG_TOP): begin
          long_d = 1'b1;
          lcnt_d = LONG_SAT;
        end
        (lcnt_q < LONG_TOP): lcnt_d = lcnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{IDLE}};
      cnt_q   <= '0;
      lcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      lcnt_q  <= lcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign evt.level = level_q;
  assign evt.press = press_q;
  assign evt.rel   = rel_q;
  assign evt.lng   = long_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer; one debounce_channel per button,
// all sharing clk, rst_n and the timebase tick.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 16,
  parameter int DEBOUNCE_COUNT = 20,
  parameter int SYNC_STAGES    = 2,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int LONG_W         = 16,
  parameter int LONG_COUNT     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  `DB_RANGE_CHECK(g_chk_ch, CHANNELS, 1, 32)

  btn_evt_t evt [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_W         (CNT_W),
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .SYNC_STAGES   (SYNC_STAGES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .LONG_W        (LONG_W),
      .LONG_COUNT    (LONG_COUNT)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .btn_in(btn_in[i]),
      .evt   (evt[i])
    );

    assign btn_level[i]   = evt[i].level;
    assign btn_press[i]   = evt[i].press;
    assign btn_release[i] = evt[i].rel;
    assign btn_long[i]    = evt[i].lng;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: 4 channels, count 4, 2 sync stages,
// active-low buttons, long press after 8 ticked cycles.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] btn_in;
  logic [3:0] lvl_o, prs_o, rel_o, lng_o;

  int total = 0;
  int bad   = 0;
  logic [3:0] lvl;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS      (4),
    .CNT_W         (16),
    .DEBOUNCE_COUNT(4),
    .SYNC_STAGES   (2),
    .ACTIVE_LOW    (1'b1),
    .LONG_W        (16),
    .LONG_COUNT    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .btn_in     (btn_in),
    .btn_level  (lvl_o),
    .btn_press  (prs_o),
    .btn_release(rel_o),
    .btn_long   (lng_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {lvl_o, prs_o, rel_o, lng_o};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs n edges; channels in m change level at edge ev (rise or fall),
  // long pulse expected on m at edge long_at; tick high every div edges.
  task automatic run(input string tag, input logic [3:0] m,
                     input bit rise, input int ev,
                     input int long_at, input int n,
                     input int div);
    logic [3:0] l, p, r, g;
    tick = (div == 1);
    for (int k = 1; k <= n; k++) begin
      step();
      tick = (((k + 1) % div) == 0);
      l = lvl;
      if (k >= ev) l = rise ? (lvl | m) : (lvl & ~m);
      p = (rise && k == ev) ? m : 4'h0;
      r = (!rise && k == ev) ? m : 4'h0;
      g = (k == long_at) ? m : 4'h0;
      chk($sformatf("%s_%0d", tag, k), {l, p, r, g});
    end
    lvl = rise ? (lvl | m) : (lvl & ~m);
  endtask

  initial begin
    rst_n  = 1'b0;
    tick   = 1'b1;
    btn_in = 4'hF;
    lvl    = 4'h0;
    repeat (3) step();
    chk("reset", 16'h0);
    rst_n = 1'b1;
    run("idle", 4'h0, 1'b1, 99, -1, 20, 1);

    btn_in[0] = 1'b0;
    run("press0", 4'h1, 1'b1, 6, 14, 16, 1);
    btn_in[0] = 1'b1;
    run("rel0", 4'h1, 1'b0, 6, -1, 10, 1);

    // bounce: low 3 samples, high 1, then low held
    btn_in[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] l, p, g;
      step();
      if (k == 3) btn_in[1] = 1'b1;
      if (k == 4) btn_in[1] = 1'b0;
      l = lvl | ((k >= 10) ? 4'h2 : 4'h0);
      p = (k == 10) ? 4'h2 : 4'h0;
      g = (k == 18) ? 4'h2 : 4'h0;
      chk($sformatf("bounce1_%0d", k), {l, p, 4'h0, g});
    end
    lvl[1] = 1'b1;
    btn_in[1] = 1'b1;
    run("rel1", 4'h2, 1'b0, 6, -1, 10, 1);

    btn_in[2] = 1'b0;
    run("tick2", 4'h4, 1'b1, 16, 48, 52, 4);
    tick = 1'b1;
    btn_in[2] = 1'b1;
    run("rel2", 4'h4, 1'b0, 6, -1, 10, 1);

    btn_in[3] = 1'b0;
    run("long3", 4'h8, 1'b1, 6, 14, 20, 1);
    btn_in[3] = 1'b1;
    run("rel3", 4'h8, 1'b0, 6, -1, 12, 1);

    btn_in[1:0] = 2'b00;
    run("sim", 4'h3, 1'b1, 6, 14, 16, 1);
    btn_in = 4'hF;
    run("simrel", 4'h3, 1'b0, 6, -1, 8, 1);

    btn_in[0] = 1'b0;
    run("hold0", 4'h1, 1'b1, 6, -1, 10, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 16'h0);
    step();
    step();
    chk("rst_hold", 16'h0);
    rst_n = 1'b1;
    lvl = 4'h0;
    run("repress0", 4'h1, 1'b1, 6, 14, 16, 1);
    btn_in = 4'hF;
    run("final_rel", 4'h1, 1'b0, 6, -1, 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Per channel: metastability synchroniser, input polarity normalisation and a debounce counter advanced by an optional timebase tick.
- Per channel outputs: clean level, one-cycle press and release pulses, and a one-shot long-press pulse.
- Sits between the board push-buttons and the counter/control logic; a single instance serves all buttons.

Parameters:
- CHANNELS, 4: number of independent button channels (1..32).
- CNT_W, 16: debounce counter width; DEBOUNCE_COUNT must be in 1..2^CNT_W-1.
- DEBOUNCE_COUNT, 20: consecutive ticked cycles an input must differ from btn_level before btn_level follows it.
- SYNC_STAGES, 2: synchroniser flops per channel (2..4).
- ACTIVE_LOW, 1: 1 means a pressed button reads 0 on btn_in; outputs are always active-high.
- LONG_W, 16: long-press counter width.
- LONG_COUNT, 0: ticked cycles of held level before btn_long fires; 0 disables long-press (btn_long is tied 0); otherwise 1..2^LONG_W-1.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk externally.
- tick  in  1  timebase enable; counters advance only when tick=1. Tie to 1 for per-clock counting.
- btn_in  in  CHANNELS  raw asynchronous button inputs.
- btn_level  out  CHANNELS  debounced level, 1 = pressed.
- btn_press  out  CHANNELS  one-cycle pulse on a 0->1 change of btn_level.
- btn_release  out  CHANNELS  one-cycle pulse on a 1->0 change of btn_level.
- btn_long  out  CHANNELS  one-cycle pulse once per press when the hold time reaches LONG_COUNT.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops are set to the idle raw level (ACTIVE_LOW ? 1 : 0).
  - All counters are 0.
  - btn_level, btn_press, btn_release and btn_long are all 0.
  - Asserting reset mid-count or mid-press discards all state; no pulse is emitted on reset entry or exit.
- Synchroniser: SYNC_STAGES flops per channel. s = last stage XOR ACTIVE_LOW.
- Debounce, per channel, on each clk edge:
  - s == btn_level: cnt <= 0, regardless of tick.
  - s != btn_level and tick=0: cnt holds.
  - s != btn_level, tick=1 and cnt < DEBOUNCE_COUNT-1: cnt <= cnt+1.
  - s != btn_level, tick=1 and cnt == DEBOUNCE_COUNT-1: btn_level <= s, cnt <= 0, and btn_press (if s=1) or btn_release (if s=0) is 1 for exactly this next cycle.
- Latency: with tick=1, a clean input step becomes visible on btn_level SYNC_STAGES+DEBOUNCE_COUNT edges after the first sampling edge.
- Any return of s to btn_level before the terminal count restarts the count from 0. Bounces never produce pulses.
- Pulses are registered and asserted in the same cycle btn_level changes. press and release are mutually exclusive per channel.
- Long press (LONG_COUNT > 0):
  - lcnt clears whenever btn_level=0.
  - While btn_level=1 and tick=1, lcnt increments.
  - When lcnt == LONG_COUNT-1 with tick=1, btn_long pulses for one cycle and lcnt saturates at LONG_COUNT. No further pulse until release.
  - The release pulse is unaffected by whether a long press fired.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- No arithmetic wraps: both counters are bounded by their compare values.

Decomposition:
- Package debounce_pkg holds the idle-level function/constant and parameter-range check macros.
- One sub-module, debounce_channel: synchroniser, debounce counter, long counter and pulse regs for a single bit.
- debounce_multi is a generate loop of CHANNELS instances sharing clk, rst_n and tick.

Test Plan:
All scenarios use CHANNELS=4, DEBOUNCE_COUNT=4, SYNC_STAGES=2, ACTIVE_LOW=1, LONG_COUNT=8 and tick=1 unless noted.
- Reset: rst_n=0 with btn_in=4'b1111, then release -> all outputs 0 and no pulses over 20 cycles.
- Clean press: btn_in[0] 1->0 at edge 0 -> btn_level[0]=1 and btn_press[0]=1 at edge 6 only. Release later -> btn_release[0] pulses 6 edges after the step.
- Bounce: btn_in[1] low for 3 cycles, high for 1, then low held -> no change until 6 edges after the final fall; exactly one press pulse.
- Tick gating: tick=1 every 4th cycle, btn_in[2] pressed -> btn_level[2] rises after 4 ticked edges following synchronisation (about 16 cycles); cnt holds between ticks.
- Long press: hold btn_in[3] -> btn_long[3] pulses exactly once, 8 edges after btn_press[3]. Release -> a btn_release pulse and no second btn_long.
- Reset mid-operation: rst_n pulsed low during a hold on channel 0 -> outputs clear immediately. After release, the still-held button re-presses with a fresh press pulse at SYNC_STAGES+4 edges.
